// File: rtl/cam_frame_chunker.sv
// cam_frame_chunker
// Takes the camera byte stream (pix_valid / cam_data / frame_done), holds one
// byte in a staging register so the final byte of a frame can be marked eof,
// buffers entries {eof, err, data} in a FIFO and re-emits them on a
// valid/ready stream cut into CHUNK_BYTES chunks with chunk/frame tags.
// Frames that overflow the FIFO are truncated, flagged with frame_err on
// their last byte, and are still terminated with frame_end.
//
// Handshake: a byte transfers on a rising clk edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_data and every
// tag hold their values, and out_valid stays 1 until the transfer happens.
module cam_frame_chunker #(
   parameter int CHUNK_BYTES = 1024,
   parameter int FIFO_DEPTH  = 2048,
   parameter int LVL_W       = 12
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pix_valid,
   input  logic [7:0]       cam_data,
   input  logic             frame_done,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_first,
   output logic             out_last,
   output logic             frame_end,
   output logic             frame_err,
   output logic [15:0]      chunk_idx,
   output logic [7:0]       frame_idx,
   output logic             overflow,
   output logic [LVL_W-1:0] fifo_level
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CHUNK_BYTES);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CHUNK_BYTES - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

   // RUN: bytes flow into staging/FIFO. DROP: the FIFO was full when a push
   // was needed; every byte is discarded until the frame ends.
   typedef enum logic [0:0] {
      RUN  = 1'b0,
      DROP = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Input side state
   // ---------------------------------------------------------------------
   state_t      state_q, state_d;
   logic        stg_valid_q, stg_valid_d;
   logic [7:0]  stg_data_q, stg_data_d;
   logic        eof_pend_q, eof_pend_d;
   logic        drop_flag_q, drop_flag_d;
   logic        overflow_q, overflow_d;

   logic        push;
   logic [9:0]  push_entry;

   // ---------------------------------------------------------------------
   // FIFO storage and pointers (extra wrap bit on pointers)
   // ---------------------------------------------------------------------
   logic [9:0]       mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      wr_ptr_seen_q;
   logic [AW:0]      rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             fifo_full;
   logic             rd_avail;
   logic             pop;
   logic [9:0]       rd_entry;

   // ---------------------------------------------------------------------
   // Output head and tagging counters
   // ---------------------------------------------------------------------
   logic             head_valid_q;
   logic [7:0]       head_data_q;
   logic             head_eof_q;
   logic             head_err_q;
   logic [CNT_W-1:0] byte_cnt_q;
   logic [15:0]      chunk_q;
   logic [7:0]       frame_q;
   logic             accept;
   logic             last_tag;

   assign fifo_full = (level_q == LVL_FULL);
   // The read side sees a write one cycle after it lands, which gives the
   // two-edge push-to-out_valid latency while still streaming 1 byte/cycle.
   assign rd_avail  = (rd_ptr_q != wr_ptr_seen_q);
   assign pop       = rd_avail & (~head_valid_q | out_ready);
   assign rd_entry  = mem[rd_ptr_q[AW-1:0]];
   assign accept    = head_valid_q & out_ready;
   assign last_tag  = (byte_cnt_q == CNT_MAX) | head_eof_q;

   // Input FSM state register plus staging / eof / drop bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= RUN;
         stg_valid_q <= 1'b0;
         stg_data_q  <= 8'h00;
         eof_pend_q  <= 1'b0;
         drop_flag_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         stg_valid_q <= stg_valid_d;
         stg_data_q  <= stg_data_d;
         eof_pend_q  <= eof_pend_d;
         drop_flag_q <= drop_flag_d;
         overflow_q  <= overflow_d;
      end
   end

   // Next-state, staging and push decision; at most one push per cycle.
   always_comb begin
      state_d     = state_q;
      stg_valid_d = stg_valid_q;
      stg_data_d  = stg_data_q;
      eof_pend_d  = eof_pend_q;
      drop_flag_d = drop_flag_q;
      overflow_d  = overflow_q;
      push        = 1'b0;
      push_entry  = {1'b0, 1'b0, stg_data_q};

      if (eof_pend_q) begin
         // Flush of the frame's last byte. It never drops; it waits for space.
         if (!fifo_full) begin
            push        = 1'b1;
            push_entry  = {1'b1, drop_flag_q, stg_data_q};
            drop_flag_d = 1'b0;
            eof_pend_d  = 1'b0;
            stg_valid_d = pix_valid;
            if (pix_valid) begin
               // This byte opens the next frame.
               stg_data_d = cam_data;
               eof_pend_d = frame_done;
            end
         end else if (pix_valid) begin
            overflow_d = 1'b1;
         end
      end else if (state_q == DROP) begin
         if (frame_done) begin
            eof_pend_d = 1'b1;
            state_d    = RUN;
         end
      end else begin
         if (pix_valid) begin
            if (!stg_valid_q) begin
               stg_valid_d = 1'b1;
               stg_data_d  = cam_data;
               eof_pend_d  = frame_done;
            end else if (!fifo_full) begin
               push       = 1'b1;
               stg_data_d = cam_data;
               eof_pend_d = frame_done;
            end else begin
               // No room: lose the new byte, keep the staged one for eof.
               overflow_d  = 1'b1;
               drop_flag_d = 1'b1;
               if (frame_done) begin
                  eof_pend_d = 1'b1;
               end else begin
                  state_d = DROP;
               end
            end
         end else if (frame_done && stg_valid_q) begin
            eof_pend_d = 1'b1;
         end
      end
   end

   // FIFO storage write; contents need no reset because pointers gate reads.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q[AW-1:0]] <= push_entry;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q      <= '0;
         wr_ptr_seen_q <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
      end else begin
         wr_ptr_seen_q <= wr_ptr_q;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      end
   end

   // Registered output head: refilled when empty or when its byte is taken.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_valid_q <= 1'b0;
         head_data_q  <= 8'h00;
         head_eof_q   <= 1'b0;
         head_err_q   <= 1'b0;
      end else if (pop) begin
         head_valid_q <= 1'b1;
         head_eof_q   <= rd_entry[9];
         head_err_q   <= rd_entry[8];
         head_data_q  <= rd_entry[7:0];
      end else if (accept) begin
         head_valid_q <= 1'b0;
      end
   end

   // Chunk/frame position counters, advanced only by accepted bytes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         byte_cnt_q <= '0;
         chunk_q    <= 16'd0;
         frame_q    <= 8'd0;
      end else if (accept) begin
         if (last_tag) begin
            byte_cnt_q <= '0;
            if (head_eof_q) begin
               chunk_q <= 16'd0;
               frame_q <= frame_q + 8'd1;
            end else begin
               chunk_q <= chunk_q + 16'd1;
            end
         end else begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
         end
      end
   end

   assign out_valid  = head_valid_q;
   assign out_data   = head_data_q;
   assign out_first  = head_valid_q & (byte_cnt_q == '0);
   assign out_last   = head_valid_q & last_tag;
   assign frame_end  = head_valid_q & head_eof_q;
   assign frame_err  = head_valid_q & head_eof_q & head_err_q;
   assign chunk_idx  = chunk_q;
   assign frame_idx  = frame_q;
   assign overflow   = overflow_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_cam_frame_chunker.sv
// Testbench for cam_frame_chunker with CHUNK_BYTES=4, FIFO_DEPTH=8.
// Stimulus pushes expected output bytes into exp_q; a monitor pops and
// compares every accepted byte, and checks that a stalled head holds still.
module tb_cam_frame_chunker;
   localparam int CB = 4;
   localparam int FD = 8;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pix_valid = 1'b0;
   logic [7:0]    cam_data = 8'h00;
   logic          frame_done = 1'b0;
   logic          out_ready = 1'b0;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_first;
   logic          out_last;
   logic          frame_end;
   logic          frame_err;
   logic [15:0]   chunk_idx;
   logic [7:0]    frame_idx;
   logic          overflow;
   logic [LW-1:0] fifo_level;

   // {data, first, last, frame_end, frame_err, chunk_idx, frame_idx}
   logic [35:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int ready_mode = 0;   // 0: always ready, 1: never ready, 2: 1,0,0,1 pattern
   int ready_phase = 0;

   cam_frame_chunker #(.CHUNK_BYTES(CB), .FIFO_DEPTH(FD), .LVL_W(LW)) dut (
      .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .cam_data(cam_data),
      .frame_done(frame_done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
      .frame_end(frame_end), .frame_err(frame_err), .chunk_idx(chunk_idx),
      .frame_idx(frame_idx), .overflow(overflow), .fifo_level(fifo_level)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic fd);
      pix_valid  = 1'b1;
      cam_data   = d;
      frame_done = fd;
      cyc();
      pix_valid  = 1'b0;
      frame_done = 1'b0;
   endtask

   task automatic end_frame();
      frame_done = 1'b1;
      cyc();
      frame_done = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic check_idle(input string name);
      chk(name, {out_valid, out_data, out_first, out_last, frame_end, frame_err,
                 chunk_idx, frame_idx, overflow, fifo_level}, 48'h0);
   endtask

   // Expected bytes of one frame of n bytes starting at value base.
   task automatic exp_frame(input logic [7:0] base, input int n, input logic [7:0] fidx,
                            input logic err);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({8'(base + i), (i % CB == 0), ((i % CB == CB - 1) || (i == n - 1)),
                          (i == n - 1), (err && (i == n - 1)), 16'(i / CB), fidx});
      end
   endtask

   task automatic wait_drain(input string name);
      int budget;
      budget = 300;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: drain timeout, %0d bytes still expected", name, exp_q.size());
         exp_q.delete();
      end
      cyc();
   endtask

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: begin
               out_ready   = (ready_phase == 0) || (ready_phase == 3);
               ready_phase = (ready_phase + 1) % 4;
            end
         endcase
      end
   end

   // Monitor / scoreboard
   logic        stalled = 1'b0;
   logic [47:0] snap = '0;
   always @(negedge clk) begin
      logic [47:0] cur;
      cur = {3'b0, out_valid, out_data, out_first, out_last, frame_end, frame_err,
             chunk_idx, frame_idx};
      if (!reset_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) chk("hold", cur, snap);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_byte: got data %h, none expected", out_data);
            end else begin
               chk("byte", {12'b0, cur[35:0]}, {12'b0, exp_q.pop_front()});
            end
         end
         stalled = out_valid && !out_ready;
         snap    = cur;
      end
   end

   // Main sequence
   initial begin
      reset_n = 1'b0;
      cyc();
      cyc();
      check_idle("reset_state");
      reset_n = 1'b1;

      // Frame of 10 bytes, chunks 4/4/2
      ready_mode = 0;
      exp_frame(8'h00, 10, 8'd0, 1'b0);
      for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
      end_frame();
      wait_drain("frame10");
      chk("frame_idx_after_frame10", 48'(frame_idx), 48'd1);

      // frame_done together with 6th byte, next byte opens frame 1
      do_reset();
      exp_frame(8'h00, 6, 8'd0, 1'b0);
      exp_frame(8'h06, 1, 8'd1, 1'b0);
      for (int i = 0; i < 5; i++) send(8'(i), 1'b0);
      send(8'h05, 1'b1);
      send(8'h06, 1'b0);
      end_frame();
      wait_drain("same_cycle_done");

      // Overflow: 20 bytes with downstream stalled
      do_reset();
      ready_mode = 1;
      cyc();
      exp_frame(8'h00, 10, 8'd0, 1'b1);
      for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
      end_frame();
      repeat (4) cyc();
      chk("ovf_fifo_level", 48'(fifo_level), 48'd8);
      chk("ovf_sticky", 48'(overflow), 48'd1);
      chk("ovf_head", {out_valid, out_data}, {1'b1, 8'h00});
      ready_mode = 0;
      wait_drain("overflow_frame");
      exp_frame(8'h20, 3, 8'd1, 1'b0);
      for (int i = 0; i < 3; i++) send(8'(8'h20 + i), 1'b0);
      end_frame();
      wait_drain("clean_after_ovf");
      chk("ovf_still_sticky", 48'(overflow), 48'd1);

      // Ready toggling 1,0,0,1 across a 6-byte frame
      do_reset();
      ready_phase = 0;
      ready_mode  = 2;
      exp_frame(8'h30, 6, 8'd0, 1'b0);
      for (int i = 0; i < 6; i++) send(8'(8'h30 + i), 1'b0);
      end_frame();
      wait_drain("toggle_ready");
      ready_mode = 0;
      cyc();

      // Empty frame: ignored
      end_frame();
      repeat (10) cyc();
      chk("empty_frame_idx", 48'(frame_idx), 48'd1);
      chk("empty_no_output", {out_valid, fifo_level}, 48'd0);

      // Reset mid-chunk while data is buffered and overflow is set
      ready_mode = 1;
      cyc();
      for (int i = 0; i < 12; i++) send(8'(8'h40 + i), 1'b0);
      cyc();
      chk("pre_reset_ovf", {overflow, fifo_level}, {1'b1, 4'd8});
      do_reset();
      check_idle("mid_frame_reset");
      ready_mode = 0;
      exp_frame(8'h50, 5, 8'd0, 1'b0);
      for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b0);
      end_frame();
      wait_drain("after_reset_frame");
      chk("final_frame_idx", 48'(frame_idx), 48'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cam_frame_chunker.md
Name: cam_frame_chunker

Overview:
- Sits between the camera pixel reader and the RAM write controller; consumes the camera byte stream (cam_data / pix_valid / frame_done), all already in the clk domain.
- Buffers bytes in an internal FIFO and re-emits them as a valid/ready stream cut into Ethernet-payload-sized chunks.
- Tags every byte with chunk/frame position, so the downstream controller never needs to count pixels.
- A frame that overflows the FIFO is truncated cleanly, flagged, and still terminated.

Parameters:
- CHUNK_BYTES, 1024: payload bytes per chunk; the last chunk of a frame may be shorter. Must be ≥2.
- FIFO_DEPTH, 2048: FIFO entries; power of 2, ≥4.
- LVL_W, 12: fifo_level width; equals log2(FIFO_DEPTH)+1.

Ports:
- clk, in, 1: single clock for the whole block.
- reset_n, in, 1: synchronous, active-low reset.
- pix_valid, in, 1: cam_data is valid this cycle.
- cam_data, in, 8: camera byte.
- frame_done, in, 1: one-cycle pulse after the last byte of a frame.
- out_data, out, 8: output byte.
- out_valid, out, 1: out_data and tags are valid.
- out_ready, in, 1: downstream accepts when out_valid & out_ready.
- out_first, out, 1: first byte of a chunk.
- out_last, out, 1: last byte of a chunk.
- frame_end, out, 1: out_last and this chunk ends the frame.
- frame_err, out, 1: valid with frame_end; the frame was truncated.
- chunk_idx, out, 16: chunk number within the frame, 0-based.
- frame_idx, out, 8: frame counter, wraps 255→0.
- overflow, out, 1: sticky; set on any dropped byte.
- fifo_level, out, LVL_W: FIFO occupancy.

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0, FIFO empty, staging register empty, counters 0, FSM = RUN. Reset mid-frame discards all buffered data with no frame_end emitted.
- FIFO entry = {eof, err, data[7:0]}.
- Staging register, one byte deep, exists so the last byte can be marked eof:
  - pix_valid with staging empty: load staging; nothing is pushed.
  - pix_valid with staging full: push staged byte (eof=0), load the new byte.
  - frame_done with staging full: set eof_pending. The next push writes the staged byte with eof=1 and err = drop flag; the drop flag then clears.
  - frame_done and pix_valid in the same cycle: the new byte belongs to the ending frame. Push old staged (eof=0), stage the new byte, set eof_pending, and flush next cycle with eof=1.
  - pix_valid during the flush cycle: the byte is staged after the flush and belongs to the next frame.
  - frame_done with staging empty and no eof_pending: ignored; frame_idx does not change.
  - At most one push per cycle.
- FSM states:
  - RUN: normal operation.
  - DROP: entered when a push is needed and the FIFO is full. The incoming byte is discarded, the staged byte is kept, overflow←1 and the drop flag←1. In DROP all pix_valid bytes are discarded.
  - frame_done in DROP sets eof_pending and returns to RUN.
- An eof flush that finds the FIFO full waits, with eof_pending held, until space frees. It never drops. pix_valid arriving during that wait is discarded and sets overflow.
- Output stage is a registered head:
  - An entry pushed at edge N appears with out_valid=1 after edge N+2 if the head is empty and nothing is ahead of it.
  - Back-to-back throughput is 1 byte/cycle while out_ready=1.
  - out_data and all tags hold stable while out_valid & !out_ready.
- Tagging uses byte_cnt, range 0..CHUNK_BYTES-1:
  - out_first = (byte_cnt==0).
  - out_last = (byte_cnt==CHUNK_BYTES-1) | eof.
  - frame_end = eof; frame_err = eof & err.
- On an accepted byte:
  - out_last accepted: byte_cnt←0.
  - If also eof: chunk_idx←0 and frame_idx←frame_idx+1; otherwise chunk_idx←chunk_idx+1.
  - Not out_last: byte_cnt←byte_cnt+1.
- fifo_level counts entries in the FIFO only, excluding staging and the output head. Simultaneous push and pop leaves it unchanged. It never exceeds FIFO_DEPTH.
- overflow clears only on reset.

Test Plan (CHUNK_BYTES=4, FIFO_DEPTH=8 unless stated):
- 10 bytes 0x00..0x09 with pix_valid, then frame_done, out_ready=1 → chunks of 4/4/2 bytes; out_first on 0x00/0x04/0x08; out_last on 0x03/0x07/0x09; frame_end and frame_err=0 only on 0x09; chunk_idx 0,1,2; frame_idx reads 1 after 0x09 is accepted.
- frame_done in the same cycle as the 6th byte 0x05 → 0x05 carries out_last=1 and frame_end=1; a byte on the following cycle is tagged out_first with chunk_idx=0 and frame_idx=1.
- out_ready=0, push 20 bytes, then frame_done → fifo_level=8, overflow=1, the 10 bytes 0x00..0x09 are emitted, and 0x09 carries frame_end=1 and frame_err=1. A following clean frame gives frame_err=0 while overflow stays 1.
- out_ready toggling 1,0,0,1 during a 6-byte frame → no byte lost or duplicated; out_data and tags are stable during stalls; sequence and tags match the first scenario's rules.
- frame_done with no bytes in the frame → no output, frame_idx unchanged.
- reset_n=0 for 1 cycle mid-chunk → next cycle all outputs 0, fifo_level=0, overflow=0; the next frame starts at chunk_idx=0, frame_idx=0.
